// File: rtl/morse_pkg.sv
// morse_pkg: shared Morse code constants, state encoding and timing
// multipliers for the receive path and the pattern matcher.
package morse_pkg;

    localparam logic [2:0] CH_S = 3'd0;
    localparam logic [2:0] CH_T = 3'd1;
    localparam logic [2:0] CH_U = 3'd2;
    localparam logic [2:0] CH_V = 3'd3;
    localparam logic [2:0] CH_W = 3'd4;
    localparam logic [2:0] CH_X = 3'd5;
    localparam logic [2:0] CH_Y = 3'd6;
    localparam logic [2:0] CH_Z = 3'd7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MARK  = 2'd1,
        SPACE = 2'd2,
        ABORT = 2'd3
    } state_t;

    localparam logic DOT  = 1'b0;
    localparam logic DASH = 1'b1;

    // Thresholds in units: glitch below 1/2, dash from 2, gap 2, stuck 4
    localparam int GLITCH_DIV = 2;
    localparam int DASH_MUL   = 2;
    localparam int GAP_MUL    = 2;
    localparam int STUCK_MUL  = 4;

endpackage

// File: rtl/morse_pattern_match.sv
// morse_pattern_match: maps a collected element pattern (first element
// in bit 0, dash=1) to its 3-bit character code.
module morse_pattern_match
    import morse_pkg::*;
(
    input  logic [2:0] n_i,
    input  logic [3:0] elem_i,
    input  logic       ovf_i,
    output logic [2:0] code_o,
    output logic       match_o
);

    always_comb begin
        code_o  = CH_S;
        match_o = 1'b0;
        case ({n_i, elem_i})
            7'b011_0000: begin code_o = CH_S; match_o = 1'b1; end
            7'b001_0001: begin code_o = CH_T; match_o = 1'b1; end
            7'b011_0100: begin code_o = CH_U; match_o = 1'b1; end
            7'b100_1000: begin code_o = CH_V; match_o = 1'b1; end
            7'b011_0110: begin code_o = CH_W; match_o = 1'b1; end
            7'b100_1001: begin code_o = CH_X; match_o = 1'b1; end
            7'b100_1101: begin code_o = CH_Y; match_o = 1'b1; end
            7'b100_0011: begin code_o = CH_Z; match_o = 1'b1; end
            default: ;
        endcase
        if (ovf_i) match_o = 1'b0;
    end

endmodule

// File: rtl/morse_receiver.sv
// morse_receiver: times marks and spaces on a synchronised key line,
// classifies dots/dashes and decodes letters S..Z on a letter gap.
module morse_receiver
    import morse_pkg::*;
#(
    parameter int UNIT_CYCLES = 25000000
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       key_in,
    output logic [2:0] char,
    output logic       char_valid,
    output logic       char_error,
    output logic       busy
);

    localparam int CNT_W = $clog2(STUCK_MUL * UNIT_CYCLES + 2);
    localparam logic [CNT_W-1:0] CNT_MAX =
        CNT_W'(STUCK_MUL * UNIT_CYCLES + 1);
    localparam logic [CNT_W-1:0] GLITCH_LEN =
        CNT_W'(UNIT_CYCLES / GLITCH_DIV);
    localparam logic [CNT_W-1:0] DASH_LEN = CNT_W'(DASH_MUL * UNIT_CYCLES);
    localparam logic [CNT_W-1:0] GAP_LEN = CNT_W'(GAP_MUL * UNIT_CYCLES);
    localparam logic [CNT_W-1:0] STUCK_LEN = CNT_W'(STUCK_MUL * UNIT_CYCLES);

    logic             sync_q, key_q, lvl_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    state_t           state_q, state_d;
    logic [3:0]       elem_q, elem_d;
    logic [2:0]       n_q, n_d;
    logic             ovf_q, ovf_d;
    logic [2:0]       char_q, char_d;
    logic             valid_q, valid_d;
    logic             error_q, error_d;
    logic [2:0]       code;
    logic             match;
    logic             mark_end, stuck, gap_done, is_glitch, is_dash;

    // cnt_q holds the run length of lvl_q, i.e. it lags key_q by a cycle
    always_comb begin
        if (key_q != lvl_q) cnt_d = CNT_W'(1);
        else if (cnt_q == CNT_MAX) cnt_d = CNT_MAX;
        else cnt_d = cnt_q + CNT_W'(1);
    end

    assign mark_end  = lvl_q & ~key_q;
    assign stuck     = lvl_q & key_q & (cnt_q == STUCK_LEN);
    assign gap_done  = ~lvl_q & ~key_q & (cnt_q >= GAP_LEN);
    assign is_glitch = cnt_q < GLITCH_LEN;
    assign is_dash   = cnt_q >= DASH_LEN;

    morse_pattern_match u_match (
        .n_i     (n_q),
        .elem_i  (elem_q),
        .ovf_i   (ovf_q),
        .code_o  (code),
        .match_o (match)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (key_q) state_d = MARK;
            MARK: begin
                if (stuck) state_d = ABORT;
                else if (mark_end)
                    state_d = (is_glitch && n_q == 3'd0) ? IDLE : SPACE;
            end
            SPACE: begin
                if (key_q) state_d = MARK;
                else if (gap_done) state_d = IDLE;
            end
            ABORT: if (gap_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        elem_d  = elem_q;
        n_d     = n_q;
        ovf_d   = ovf_q;
        char_d  = char_q;
        valid_d = 1'b0;
        error_d = 1'b0;
        case (state_q)
            MARK: begin
                if (stuck) begin
                    error_d = 1'b1;
                    elem_d  = 4'd0;
                    n_d     = 3'd0;
                    ovf_d   = 1'b0;
                end else if (mark_end && !is_glitch) begin
                    if (n_q == 3'd4) begin
                        ovf_d = 1'b1;
                    end else begin
                        elem_d[n_q[1:0]] = is_dash ? DASH : DOT;
                        n_d = n_q + 3'd1;
                    end
                end
            end
            SPACE: begin
                if (!key_q && gap_done) begin
                    valid_d = match;
                    error_d = ~match;
                    if (match) char_d = code;
                    elem_d = 4'd0;
                    n_d    = 3'd0;
                    ovf_d  = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_q  <= 1'b0;
            key_q   <= 1'b0;
            lvl_q   <= 1'b0;
            cnt_q   <= '0;
            elem_q  <= 4'd0;
            n_q     <= 3'd0;
            ovf_q   <= 1'b0;
            char_q  <= 3'd0;
            valid_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            sync_q  <= key_in;
            key_q   <= sync_q;
            lvl_q   <= key_q;
            cnt_q   <= cnt_d;
            elem_q  <= elem_d;
            n_q     <= n_d;
            ovf_q   <= ovf_d;
            char_q  <= char_d;
            valid_q <= valid_d;
            error_q <= error_d;
        end
    end

    assign char       = char_q;
    assign char_valid = valid_q;
    assign char_error = error_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_morse_receiver.sv
// tb_morse_receiver: directed and randomized key sequences checked every
// cycle against a run-length based model of Morse letter decoding.
module tb_morse_receiver;

    localparam int U = 8;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       key_in = 1'b0;
    logic [2:0] char;
    logic       char_valid, char_error, busy;

    morse_receiver #(.UNIT_CYCLES(U)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .key_in     (key_in),
        .char       (char),
        .char_valid (char_valid),
        .char_error (char_error),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    string pats [0:7] = '{"...", "-", "..-", "...-",
                          ".--", "-..-", "-.--", "--.."};

    // model state: key history, current key_s run, collected symbol
    logic hist1, hist2, cur_lv;
    int   runlen;
    bit   busy_m, abort_m, ovf_m;
    bit   sym [$];
    logic exp_valid, exp_error, exp_busy;
    logic [2:0] exp_char;
    int   m_nvalid = 0, m_nerr = 0, m_last = 0;

    // observed DUT pulses
    int nvalid = 0, nerr = 0, last_v_cyc = 0, last_e_cyc = 0;
    logic [2:0] last_char = 3'd0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0d required=%0d",
                     name, cyc, act, req);
        end
    endtask

    task automatic model_reset();
        hist1 = 0; hist2 = 0; cur_lv = 0; runlen = 0;
        busy_m = 0; abort_m = 0; ovf_m = 0; sym.delete();
        exp_valid = 0; exp_error = 0; exp_busy = 0; exp_char = 3'd0;
    endtask

    task automatic add_mark(input int len);
        if (len < U / 2) begin
            if (sym.size() == 0 && !ovf_m) busy_m = 0;
        end else if (sym.size() == 4) begin
            ovf_m = 1;
        end else begin
            sym.push_back(len >= 2 * U);
        end
    endtask

    task automatic letter_end();
        string s;
        int code;
        s = "";
        code = -1;
        foreach (sym[i]) begin
            if (sym[i]) s = {s, "-"};
            else s = {s, "."};
        end
        for (int i = 0; i < 8; i++) if (pats[i] == s) code = i;
        if (!ovf_m && code >= 0) begin
            exp_valid = 1; exp_char = code[2:0];
            m_nvalid++; m_last = code;
        end else begin
            exp_error = 1; m_nerr++;
        end
        sym.delete(); ovf_m = 0;
    endtask

    // one step per clock: consumes the key_s value of the previous cycle
    task automatic model_step();
        logic b;
        int prev;
        bit edge_seen;
        b = hist2; hist2 = hist1; hist1 = key_in;
        exp_valid = 0; exp_error = 0;
        prev = runlen; edge_seen = 0;
        if (b == cur_lv) runlen++;
        else begin cur_lv = b; runlen = 1; edge_seen = 1; end
        if (edge_seen && b && !abort_m) busy_m = 1;
        if (edge_seen && !b && busy_m && !abort_m) add_mark(prev);
        if (b && busy_m && !abort_m && runlen == 4 * U + 1) begin
            exp_error = 1; m_nerr++; abort_m = 1;
            sym.delete(); ovf_m = 0;
        end
        if (!b && busy_m && runlen == 2 * U + 1) begin
            if (abort_m) abort_m = 0;
            else letter_end();
            busy_m = 0;
        end
        exp_busy = busy_m;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clock);
            cyc++;
            if (!reset_n) model_reset();
            else model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clock);
            if (reset_n) begin
                chk("char_valid", int'(char_valid), int'(exp_valid));
                chk("char_error", int'(char_error), int'(exp_error));
                chk("busy", int'(busy), int'(exp_busy));
                if (exp_valid) chk("char", int'(char), int'(exp_char));
                if (char_valid && char_error)
                    chk("valid_and_error", 1, 0);
                if (char_valid) begin
                    nvalid++; last_v_cyc = cyc; last_char = char;
                end
                if (char_error) begin
                    nerr++; last_e_cyc = cyc;
                end
            end
        end
    end

    task automatic seg(input logic lv, input int n);
        key_in = lv;
        repeat (n) @(negedge clock);
    endtask

    task automatic send(input string p, input int dl, input int dh,
                        input int gap, input int endgap, output int fd);
        for (int i = 0; i < p.len(); i++) begin
            seg(1'b1, (p[i] == "-") ? dh : dl);
            if (i < p.len() - 1) seg(1'b0, gap);
        end
        fd = cyc;
        seg(1'b0, endgap);
        #1;
    endtask

    task automatic rand_sym();
        int kind, len;
        string p;
        kind = $urandom_range(0, 9);
        if (kind == 8) begin
            seg(1'b1, $urandom_range(33, 45));
            seg(1'b0, $urandom_range(17, 30));
            return;
        end
        if (kind < 6) begin
            p = pats[$urandom_range(0, 7)];
        end else begin
            p = "";
            len = $urandom_range(1, 6);
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 1) == 1) p = {p, "-"};
                else p = {p, "."};
            end
        end
        for (int i = 0; i < p.len(); i++) begin
            if (p[i] == "-") seg(1'b1, $urandom_range(16, 32));
            else seg(1'b1, $urandom_range(4, 15));
            if (i < p.len() - 1) begin
                if (kind == 9) begin
                    seg(1'b0, $urandom_range(1, 6));
                    seg(1'b1, $urandom_range(1, 3));
                end
                seg(1'b0, $urandom_range(1, 16));
            end
        end
        seg(1'b0, $urandom_range(17, 30));
    endtask

    int fd, v0, e0, mv0, d;

    initial begin
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clock);
        #1;
        chk("rst_char", int'(char), 0);
        chk("rst_valid", int'(char_valid), 0);
        chk("rst_error", int'(char_error), 0);
        chk("rst_busy", int'(busy), 0);
        reset_n = 1'b1;
        seg(1'b0, 5);

        v0 = nvalid; e0 = nerr; mv0 = m_nvalid;
        send("...", 8, 24, 8, 20, fd);
        chk("S_count", nvalid - v0, 1);
        chk("S_char", int'(last_char), 0);
        chk("S_latency", last_v_cyc - fd, 2 * U + 3);
        chk("S_noerr", nerr - e0, 0);
        chk("S_model_count", m_nvalid - mv0, 1);
        chk("S_model_char", m_last, 0);

        send("-.--", 8, 24, 8, 20, fd);
        chk("Y_char", int'(last_char), 6);
        chk("Y_model_char", m_last, 6);

        v0 = nvalid;
        seg(1'b1, 8); seg(1'b0, 3); seg(1'b1, 3); seg(1'b0, 4);
        seg(1'b1, 8); seg(1'b0, 8);
        seg(1'b1, 8); seg(1'b0, 2); seg(1'b1, 3); seg(1'b0, 20);
        #1;
        chk("Sglitch_count", nvalid - v0, 1);
        chk("Sglitch_char", int'(last_char), 0);

        send("-", 8, 16, 8, 20, fd);
        chk("T16_char", int'(last_char), 1);

        v0 = nvalid; e0 = nerr;
        send(".", 15, 16, 8, 20, fd);
        chk("E15_err", nerr - e0, 1);
        chk("E15_novalid", nvalid - v0, 0);

        send("..-", 4, 16, 8, 20, fd);
        chk("U4_char", int'(last_char), 2);

        send("...-", 15, 16, 8, 20, fd);
        chk("V15_char", int'(last_char), 3);

        v0 = nvalid; e0 = nerr;
        seg(1'b1, 3); seg(1'b0, 20);
        #1;
        chk("glitch_nopulse", (nvalid - v0) + (nerr - e0), 0);
        chk("glitch_idle", int'(busy), 0);

        v0 = nvalid; e0 = nerr;
        send(".....", 8, 24, 8, 20, fd);
        chk("five_err", nerr - e0, 1);
        chk("five_novalid", nvalid - v0, 0);

        e0 = nerr; v0 = nvalid;
        #1 d = cyc;
        seg(1'b1, 40);
        #1;
        chk("stuck_err", nerr - e0, 1);
        chk("stuck_time", last_e_cyc - d, 4 * U + 3);
        chk("stuck_busy", int'(busy), 1);
        seg(1'b0, 20);
        #1;
        chk("stuck_nomore", (nerr - e0) + (nvalid - v0), 1);
        chk("stuck_idle", int'(busy), 0);

        v0 = nvalid; e0 = nerr;
        seg(1'b1, 8); seg(1'b0, 8); seg(1'b1, 8); seg(1'b0, 8);
        seg(1'b1, 8); seg(1'b0, 4);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_char", int'(char), 0);
        chk("arst_valid", int'(char_valid), 0);
        chk("arst_error", int'(char_error), 0);
        chk("arst_busy", int'(busy), 0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        seg(1'b0, 4);
        send("--..", 8, 24, 8, 20, fd);
        chk("Z_char", int'(last_char), 7);
        chk("Z_count", nvalid - v0, 1);
        chk("Z_noerr", nerr - e0, 0);

        for (int k = 0; k < 150; k++) rand_sym();
        seg(1'b0, 30);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
